// File: rtl/mult_arbiter_pkg.sv
// Shared types and width helpers for the round-robin multiplier arbiter.
package mult_arbiter_pkg;

   localparam int unsigned N_REQ_MAX = 16;

   // Index width for n requesters, never narrower than one bit
   function automatic int unsigned id_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned ID_W = id_w(N_REQ_MAX);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester/result bus between the channel units and the shared multiplier.
interface mult_arbiter_if #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned WIDTH_A = 16,
   parameter int unsigned WIDTH_B = 16
);
   import mult_arbiter_pkg::*;

   localparam int unsigned IW = id_w(N_REQ);
   localparam int unsigned PW = WIDTH_A + WIDTH_B;

   logic [N_REQ-1:0]              req_valid;
   logic [N_REQ-1:0][WIDTH_A-1:0] req_a;
   logic [N_REQ-1:0][WIDTH_B-1:0] req_b;
   logic [N_REQ-1:0]              req_ready;
   logic                          res_valid;
   logic [IW-1:0]                 res_id;
   logic [PW-1:0]                 res_p;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, res_valid, res_id, res_p
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, res_valid, res_id, res_p
   );

endinterface

// File: rtl/mult_arbiter_mult.sv
// Pipelined unsigned multiplier; product appears LATENCY clocks after the operands.
module mult #(
   parameter int unsigned WIDTH_A = 16,
   parameter int unsigned WIDTH_B = 16,
   parameter int unsigned LATENCY = 3,
   localparam int unsigned PW     = WIDTH_A + WIDTH_B
) (
   input  logic               clk,
   input  logic [WIDTH_A-1:0] a_i,
   input  logic [WIDTH_B-1:0] b_i,
   output logic [PW-1:0]      p_o
);

   logic [PW-1:0] p_q [LATENCY];

   // Datapath only; validity travels in the arbiter's tag pipeline
   always_ff @(posedge clk) begin
      p_q[0] <= PW'(a_i) * PW'(b_i);
      for (int unsigned s = 1; s < LATENCY; s++) begin
         p_q[s] <= p_q[s-1];
      end
   end

   assign p_o = p_q[LATENCY-1];

endmodule

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_picker
   import mult_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned IW   = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IW-1:0]    idx_o,
   output logic             any_o
);

   always_comb begin
      logic [IW-1:0] j;
      logic          found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         j = IW'((32'(ptr_i) + k) % N_REQ);
         if (!found && req_i[j]) begin
            gnt_o[j] = 1'b1;
            idx_o    = j;
            found    = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined multiplier among N_REQ requesters,
// with a tag pipeline that routes each product back to its owner.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned WIDTH_A = 16,
   parameter int unsigned WIDTH_B = 16,
   parameter int unsigned LATENCY = 3
) (
   input  logic           clk,
   input  logic           rst,
   mult_arbiter_if.slave  bus
);

   localparam int unsigned IW = id_w(N_REQ);
   localparam int unsigned PW = WIDTH_A + WIDTH_B;

   logic [IW-1:0]      ptr_q, ptr_d;
   logic [N_REQ-1:0]   gnt;
   logic [IW-1:0]      win_idx;
   logic               win_any;
   tag_t               tag_in;
   tag_t               tag_q [LATENCY];
   logic [WIDTH_A-1:0] op_a;
   logic [WIDTH_B-1:0] op_b;
   logic [PW-1:0]      prod;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req_i (bus.req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (win_idx),
      .any_o (win_any)
   );

   // The grant is always taken when any request is valid, so accept == win_any
   always_comb begin
      ptr_d  = ptr_q;
      tag_in = '0;
      if (win_any) begin
         ptr_d        = (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + IW'(1);
         tag_in.valid = 1'b1;
         tag_in.id    = ID_W'(win_idx);
      end
   end

   assign op_a = bus.req_a[win_idx];
   assign op_b = bus.req_b[win_idx];

   mult #(
      .WIDTH_A (WIDTH_A),
      .WIDTH_B (WIDTH_B),
      .LATENCY (LATENCY)
   ) u_mult (
      .clk (clk),
      .a_i (op_a),
      .b_i (op_b),
      .p_o (prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         for (int unsigned s = 0; s < LATENCY; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         ptr_q    <= ptr_d;
         tag_q[0] <= tag_in;
         for (int unsigned s = 1; s < LATENCY; s++) begin
            tag_q[s] <= tag_q[s-1];
         end
      end
   end

   assign bus.req_ready = gnt;
   assign bus.res_valid = tag_q[LATENCY-1].valid;
   assign bus.res_id    = IW'(tag_q[LATENCY-1].id);
   assign bus.res_p     = prod;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized checks of grant order, result latency and routing.
module tb_mult_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned WA  = 16;
   localparam int unsigned WB  = 16;
   localparam int unsigned LAT = 3;

   typedef struct {
      int          id;
      logic [31:0] p;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mult_arbiter_if #(.N_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB)) bus ();

   mult_arbiter #(
      .N_REQ   (N),
      .WIDTH_A (WA),
      .WIDTH_B (WB),
      .LATENCY (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   function automatic int ref_pick(input logic [3:0] v, input int p);
      for (int off = 0; off < 4; off++) begin
         if (v[(p + off) % 4]) return (p + off) % 4;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      idle();
      bus.req_valid = 4'b1010;
      tick();
      total++;
      if (bus.res_valid !== 1'b0) begin
         bad++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid);
      end
      total++;
      if (bus.res_id !== 2'd0) begin
         bad++; $display("FAIL reset_res_id: got %0d want 0", bus.res_id);
      end
      total++;
      if (bus.req_ready !== 4'b0010) begin
         bad++; $display("FAIL reset_ready: got %b want 0010", bus.req_ready);
      end
      idle();
      rst = 1'b0;
      #1;
      total++;
      if (bus.req_ready !== 4'b0000) begin
         bad++; $display("FAIL reset_ready_idle: got %b want 0000", bus.req_ready);
      end
      bus.req_valid = 4'b1111;
      #1;
      total++;
      if (bus.req_ready !== 4'b0001) begin
         bad++; $display("FAIL reset_ready_all: got %b want 0001", bus.req_ready);
      end
      idle();
   endtask

   task automatic test_single();
      do_reset();
      bus.req_valid = 4'b0100;
      bus.req_a[2]  = 16'd300;
      bus.req_b[2]  = 16'd7;
      #1;
      total++;
      if (bus.req_ready !== 4'b0100) begin
         bad++; $display("FAIL single_ready: got %b want 0100", bus.req_ready);
      end
      tick();
      idle();
      for (int c = 1; c < 3; c++) begin
         total++;
         if (bus.res_valid !== 1'b0) begin
            bad++; $display("FAIL single_early_valid: cycle %0d got %b want 0", c, bus.res_valid);
         end
         tick();
      end
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_p !== 32'd2100) begin
         bad++;
         $display("FAIL single_result: got v=%b id=%0d p=%0d want v=1 id=2 p=2100",
                  bus.res_valid, bus.res_id, bus.res_p);
      end
      tick();
      total++;
      if (bus.res_valid !== 1'b0) begin
         bad++; $display("FAIL single_after: got %b want 0", bus.res_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_p;
      int          id;
      do_reset();
      bus.req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i] = 16'(100 * (i + 1) + 1);
         bus.req_b[i] = 16'(i + 3);
      end
      for (int k = 0; k < 12; k++) begin
         if (k >= 8) bus.req_valid = '0;
         #1;
         if (k < 8) begin
            total++;
            if (bus.req_ready !== 4'(1 << (k % 4))) begin
               bad++; $display("FAIL rr_grant: cycle %0d got %b want %b", k, bus.req_ready, 4'(1 << (k % 4)));
            end
         end
         if (k >= 3 && k < 11) begin
            id    = (k - 3) % 4;
            exp_p = 32'((100 * (id + 1) + 1) * (id + 3));
            total++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(id) || bus.res_p !== exp_p) begin
               bad++;
               $display("FAIL rr_result: cycle %0d got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d",
                        k, bus.res_valid, bus.res_id, bus.res_p, id, exp_p);
            end
         end else begin
            total++;
            if (bus.res_valid !== 1'b0) begin
               bad++; $display("FAIL rr_idle_valid: cycle %0d got %b want 0", k, bus.res_valid);
            end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_max();
      do_reset();
      bus.req_valid = 4'b0001;
      bus.req_a[0]  = 16'hFFFF;
      bus.req_b[0]  = 16'hFFFF;
      #1;
      total++;
      if (bus.req_ready !== 4'b0001) begin
         bad++; $display("FAIL max_ready: got %b want 0001", bus.req_ready);
      end
      tick();
      idle();
      tick();
      tick();
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_p !== 32'hFFFE0001) begin
         bad++;
         $display("FAIL max_result: got v=%b id=%0d p=%h want v=1 id=0 p=fffe0001",
                  bus.res_valid, bus.res_id, bus.res_p);
      end
   endtask

   task automatic test_fairness();
      int   g3_cyc;
      logic g3_done;
      logic zero_after;
      g3_cyc     = 99;
      g3_done    = 1'b0;
      zero_after = 1'b0;
      do_reset();
      bus.req_a[0] = 16'd11; bus.req_b[0] = 16'd2;
      bus.req_a[3] = 16'd13; bus.req_b[3] = 16'd4;
      for (int c = 0; c < 13; c++) begin
         bus.req_valid = {(c >= 5 && !g3_done), 2'b00, 1'b1};
         #1;
         if (c < 5) begin
            total++;
            if (bus.req_ready !== 4'b0001) begin
               bad++; $display("FAIL fair_solo: cycle %0d got %b want 0001", c, bus.req_ready);
            end
         end
         if (c == 5) begin
            total++;
            if (bus.req_ready !== 4'b1000) begin
               bad++; $display("FAIL fair_cycle5: got %b want 1000", bus.req_ready);
            end
         end
         if (bus.req_valid[3] && bus.req_ready[3]) begin
            g3_cyc  = c;
            g3_done = 1'b1;
         end
         if (c > 5 && bus.req_ready[0]) zero_after = 1'b1;
         tick();
      end
      idle();
      total++;
      if (g3_cyc > 9) begin
         bad++; $display("FAIL fair_req3_latency: granted cycle %0d want <= 9", g3_cyc);
      end
      total++;
      if (!zero_after) begin
         bad++; $display("FAIL fair_req0_starved: got no grant after cycle 5 want grant");
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      bus.req_valid = 4'b0011;
      bus.req_a[0] = 16'd10; bus.req_b[0] = 16'd10;
      bus.req_a[1] = 16'd20; bus.req_b[1] = 16'd20;
      #1;
      tick();
      bus.req_valid = 4'b0010;
      #1;
      tick();
      idle();
      #1;
      rst = 1'b1;
      #1;
      for (int c = 0; c < 6; c++) begin
         if (c == 2) rst = 1'b0;
         #1;
         total++;
         if (bus.res_valid !== 1'b0) begin
            bad++; $display("FAIL midflight_pulse: cycle %0d got %b want 0", c, bus.res_valid);
         end
         tick();
      end
      bus.req_valid = 4'b1010;
      bus.req_a[1]  = 16'd5; bus.req_b[1] = 16'd9;
      bus.req_a[3]  = 16'd6; bus.req_b[3] = 16'd7;
      #1;
      total++;
      if (bus.req_ready !== 4'b0010) begin
         bad++; $display("FAIL midflight_first_grant: got %b want 0010", bus.req_ready);
      end
      tick();
      idle();
      tick();
      tick();
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 || bus.res_p !== 32'd45) begin
         bad++;
         $display("FAIL midflight_result: got v=%b id=%0d p=%0d want v=1 id=1 p=45",
                  bus.res_valid, bus.res_id, bus.res_p);
      end
   endtask

   task automatic test_stress();
      exp_t        q[$];
      exp_t        e;
      logic [3:0]  v;
      logic [15:0] ra [4];
      logic [15:0] rb [4];
      int          ptr;
      int          w;
      logic [3:0]  want_rdy;
      do_reset();
      v   = '0;
      ptr = 0;
      for (int i = 0; i < 4; i++) begin
         ra[i] = '0;
         rb[i] = '0;
      end
      for (int cyc = 0; cyc < 10006; cyc++) begin
         for (int i = 0; i < 4; i++) begin
            if (cyc < 10000 && !v[i] && $urandom_range(0, 2) != 0) begin
               v[i]  = 1'b1;
               ra[i] = 16'($urandom);
               rb[i] = 16'($urandom);
            end
            bus.req_a[i] = ra[i];
            bus.req_b[i] = rb[i];
         end
         bus.req_valid = v;
         #1;
         w        = ref_pick(v, ptr);
         want_rdy = (w < 0) ? 4'b0000 : 4'(1 << w);
         total++;
         if (bus.req_ready !== want_rdy) begin
            bad++; $display("FAIL stress_grant: cycle %0d got %b want %b", cyc, bus.req_ready, want_rdy);
         end
         while (q.size() > 0 && q[0].cyc < cyc - 3) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL stress_missing: id=%0d accepted %0d got no result want one", e.id, e.cyc);
         end
         if (q.size() > 0 && q[0].cyc == cyc - 3) begin
            e = q.pop_front();
            total++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(e.id) || bus.res_p !== e.p) begin
               bad++;
               $display("FAIL stress_result: cycle %0d got v=%b id=%0d p=%h want v=1 id=%0d p=%h",
                        cyc, bus.res_valid, bus.res_id, bus.res_p, e.id, e.p);
            end
         end else begin
            total++;
            if (bus.res_valid !== 1'b0) begin
               bad++; $display("FAIL stress_spurious: cycle %0d got %b want 0", cyc, bus.res_valid);
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (v[i] && bus.req_ready[i]) begin
               e.id  = i;
               e.p   = 32'(ra[i]) * 32'(rb[i]);
               e.cyc = cyc;
               q.push_back(e);
               v[i]  = 1'b0;
            end
         end
         if (w >= 0) ptr = (w + 1) % 4;
         tick();
      end
      idle();
      total++;
      if (q.size() != 0) begin
         bad++; $display("FAIL stress_leftover: got %0d pending want 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_max();
      test_fairness();
      test_reset_midflight();
      test_stress();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
